// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer and its helpers.
// The state enum uses the names the sequencer is described with: IDLE, SETTLE, HOLD.
package mux_scan_pkg;

    localparam int CH_NUM   = 8;
    localparam int SEL_W    = 3;
    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/mux_8x1.sv
// The team's 8:1 single-bit multiplexer; purely combinational.
// The scan sequencer drives s and reads y back.
module mux_8x1 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       y
);

    assign y = d[s];

endmodule

// File: rtl/mux_scan_next_chan.sv
// Combinational search for the lowest set mask bit strictly above an index.
// Feeding index -1 yields the first set channel of the mask.
module mux_scan_next_chan
    import mux_scan_pkg::*;
(
    input  logic [CH_NUM-1:0]       mask,
    input  logic signed [SEL_W:0]   idx,
    output logic [SEL_W-1:0]        next_ch,
    output logic                    found
);

    // Walk downwards so the lowest qualifying channel is the last one written.
    always_comb begin
        next_ch = '0;
        found   = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                next_ch = SEL_W'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the masked channels of an 8:1 mux with a programmable settle time
// and hands the assembled 8-bit sample word downstream over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::scan_state_t, mux_scan_pkg::CH_NUM, mux_scan_pkg::SEL_W,
           mux_scan_pkg::SETTLE_W, mux_scan_pkg::IDLE, mux_scan_pkg::HOLD;
#(
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CH_NUM-1:0] chan_mask,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_y,
    output logic              busy,
    output logic [CH_NUM-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready
);

    // The sample is taken on the edge where the counter reaches SETTLE-1,
    // so each select value is held exactly SETTLE cycles.
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);

    scan_state_t         state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CH_NUM-1:0]   mask_q, mask_d;
    logic [CH_NUM-1:0]   shadow_q, shadow_d;
    logic [CH_NUM-1:0]   data_out_q, data_out_d;
    logic                valid_q, valid_d;

    logic [SEL_W-1:0]    first_ch, next_ch;
    logic                first_found, next_found;

    mux_scan_next_chan u_first (
        .mask    (chan_mask),
        .idx     ({(SEL_W + 1){1'b1}}),
        .next_ch (first_ch),
        .found   (first_found)
    );

    mux_scan_next_chan u_next (
        .mask    (mask_q),
        .idx     ($signed({1'b0, sel_q})),
        .next_ch (next_ch),
        .found   (next_found)
    );

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        mask_d     = mask_q;
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d   = chan_mask;
                    shadow_d = '0;
                    if (first_found) begin
                        sel_d   = first_ch;
                        cnt_d   = '0;
                        state_d = mux_scan_pkg::SETTLE;
                    end else begin
                        data_out_d = '0;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end

            mux_scan_pkg::SETTLE: begin
                cnt_d = cnt_q + SETTLE_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    shadow_d[sel_q] = mux_y;
                    if (next_found) begin
                        sel_d = next_ch;
                        cnt_d = '0;
                    end else begin
                        // Final bit is merged in the same edge it is sampled.
                        data_out_d = shadow_d;
                        valid_d    = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (valid_q && data_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_q      <= '0;
            mask_q     <= '0;
            shadow_q   <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            mask_q     <= mask_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
        end
    end

    assign sel        = sel_q;
    assign busy       = (state_q != IDLE);
    assign data_out   = data_out_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench: sequencer driving the 8:1 mux, directed and random scans
// compared against a set-bit-walk reference model.
module tb_mux_scan_ctrl;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] chan_mask = '0;
    logic [2:0] sel;
    logic       mux_y;
    logic       busy;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic [7:0] mux_d = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chan_mask  (chan_mask),
        .sel        (sel),
        .mux_y      (mux_y),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready)
    );

    mux_8x1 u_mux (
        .d (mux_d),
        .s (sel),
        .y (mux_y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sel"},   32'(sel), 32'd0);
        check({tag, " busy"},  32'(busy), 32'd0);
        check({tag, " valid"}, 32'(data_valid), 32'd0);
        check({tag, " data"},  32'(data_out), 32'd0);
    endtask

    // Reference model: the word is the mux inputs restricted to the mask, the select
    // visits each set bit in ascending order for SETTLE cycles, a zero mask finishes at once.
    task automatic run_scan(input logic [7:0] m, input logic [7:0] din,
                            input int ready_delay, input bit pulse_start);
        int         seq[$];
        logic [7:0] exp_word;
        logic [2:0] sel_before;

        exp_word   = din & m;
        sel_before = sel;
        for (int ch = 0; ch < 8; ch++)
            if (m[ch])
                for (int r = 0; r < SETTLE; r++)
                    seq.push_back(ch);

        mux_d     = din;
        chan_mask = m;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chan_mask = 8'($urandom);

        if (seq.size() == 0) begin
            check("zero valid k", 32'(data_valid), 32'd1);
            check("zero data k",  32'(data_out), 32'd0);
            check("zero sel k",   32'(sel), 32'(sel_before));
            tick();
            check("zero valid k+1", 32'(data_valid), 32'd1);
            check("zero data k+1",  32'(data_out), 32'd0);
            check("zero sel k+1",   32'(sel), 32'(sel_before));
        end else begin
            foreach (seq[j]) begin
                check("scan sel",   32'(sel), 32'(seq[j]));
                check("scan busy",  32'(busy), 32'd1);
                check("scan valid", 32'(data_valid), 32'd0);
                start = (pulse_start && j == 1);
                tick();
            end
            start = 1'b0;
            check("done valid", 32'(data_valid), 32'd1);
            check("done data",  32'(data_out), 32'(exp_word));
        end
        check("hold busy", 32'(busy), 32'd1);

        for (int c = 0; c < ready_delay; c++) begin
            start = pulse_start && (c == ready_delay / 2);
            tick();
            check("bp valid", 32'(data_valid), 32'd1);
            check("bp data",  32'(data_out), 32'(exp_word));
        end

        data_ready = 1'b1;
        start      = pulse_start;
        tick();
        data_ready = 1'b0;
        start      = 1'b0;
        check("accept valid", 32'(data_valid), 32'd0);
        check("accept busy",  32'(busy), 32'd0);
        check("accept data",  32'(data_out), 32'(exp_word));
    endtask

    initial begin
        // Asynchronous reset between edges, before any clock activity.
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        check_reset_outputs("post reset idle");

        run_scan(8'hFF, 8'hA5, 0, 1'b0);
        run_scan(8'h81, 8'hFF, 0, 1'b0);
        run_scan(8'h00, 8'h5A, 1, 1'b0);

        // Backpressure with ignored starts, including one at acceptance.
        run_scan(8'h3C, 8'hC3, 10, 1'b1);
        tick();
        check("no queued scan 1", 32'(busy), 32'd0);
        tick();
        check("no queued scan 2", 32'(busy), 32'd0);
        check("no queued valid",  32'(data_valid), 32'd0);

        // Reset mid-scan after channel 3 has been sampled.
        mux_d     = 8'h6B;
        chan_mask = 8'hFF;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (4 * SETTLE) tick();
        check("mid sel before rst", 32'(sel), 32'd4);
        #3 rst = 1'b1;
        #1 check_reset_outputs("mid reset");
        @(posedge clk);
        #3 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("after rst valid", 32'(data_valid), 32'd0);
            check("after rst busy",  32'(busy), 32'd0);
        end
        run_scan(8'hFF, 8'h6B, 0, 1'b0);

        // Randomized scans, some back-to-back, some with idle gaps.
        for (int it = 0; it < 25; it++) begin
            logic [7:0] m;
            m = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                m = 8'h00;
            run_scan(m, 8'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
